// File: rtl/conv_out_writer.sv
// conv_out_writer: buffers 32-lane result batches from the conv engine and
// serializes them into byte writes (HWC layout) starting at a per-pixel base.
//
// Control FSM
//   state    | meaning
//   C_IDLE   | waiting for start
//   C_ACTIVE | accepting batches, writer draining the FIFO
//   C_DONE   | pixel_done pulse cycle, back to idle next
// Writer FSM
//   state    | meaning
//   W_IDLE   | FIFO empty, nothing presented
//   W_WRITE  | presenting one byte of the head batch
module conv_out_writer #(
    parameter int LANES  = 32,
    parameter int ADDR_W = 24,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        pix_base,
    input  logic [10:0]              c_out,
    input  logic                     in_valid,
    input  logic [8:0]               in_ch_base,
    input  logic [5:0]               in_count,
    input  logic signed [7:0]        in_data [0:LANES-1],
    input  logic                     in_done,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [7:0]               wr_data,
    input  logic                     wr_ready,
    output logic                     busy,
    output logic                     pixel_done,
    output logic                     overflow,
    output logic                     count_err
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {C_IDLE, C_ACTIVE, C_DONE} ctrl_e;
    typedef enum logic {W_IDLE, W_WRITE} wstate_e;

    ctrl_e             ctrl_q, ctrl_d;
    wstate_e           w_state_q, w_state_d;
    logic [ADDR_W-1:0] pix_base_q, pix_base_d;
    logic [10:0]       c_out_q, c_out_d;
    logic [10:0]       written_q, written_d;
    logic              seen_done_q, seen_done_d;
    logic              busy_q, busy_d;
    logic              pixel_done_q, pixel_done_d;
    logic              overflow_q, overflow_d;
    logic              count_err_q, count_err_d;
    logic [5:0]        lane_q, lane_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    // Batch storage has no reset: occupancy alone says what is valid.
    logic [7:0]        fifo_data_q [DEPTH][LANES];
    logic [8:0]        fifo_ch_q   [DEPTH];
    logic [5:0]        fifo_cnt_q  [DEPTH];

    logic              push_req, push, pop, full, drop;
    logic [5:0]        eff_cnt;
    logic              load, written_inc;
    logic [PTR_W-1:0]  load_ptr;
    logic [5:0]        load_lane;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Writer: walk the head batch lane by lane; chain straight into the next entry.
    always_comb begin
        w_state_d   = w_state_q;
        lane_d      = lane_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        pop         = 1'b0;
        written_inc = 1'b0;
        load        = 1'b0;
        load_ptr    = rd_ptr_q;
        load_lane   = '0;
        case (w_state_q)
            W_IDLE: begin
                if (occ_q != '0) begin
                    load      = 1'b1;
                    w_state_d = W_WRITE;
                end
            end
            W_WRITE: begin
                if (wr_ready) begin
                    written_inc = 1'b1;
                    if ((lane_q + 6'd1) == fifo_cnt_q[rd_ptr_q]) begin
                        pop = 1'b1;
                        if (occ_q > OCC_W'(1)) begin
                            load     = 1'b1;
                            load_ptr = ptr_inc(rd_ptr_q);
                        end else begin
                            w_state_d = W_IDLE;
                            wr_en_d   = 1'b0;
                        end
                    end else begin
                        load      = 1'b1;
                        load_lane = lane_q + 6'd1;
                    end
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (load) begin
            wr_en_d   = 1'b1;
            lane_d    = load_lane;
            wr_addr_d = pix_base_q + ADDR_W'(fifo_ch_q[load_ptr]) + ADDR_W'(load_lane);
            wr_data_d = fifo_data_q[load_ptr][load_lane[LANE_W-1:0]];
        end
    end

    // FIFO bookkeeping: a push into a full FIFO survives only if the head pops this cycle.
    always_comb begin
        eff_cnt  = (in_count > 6'(LANES)) ? 6'(LANES) : in_count;
        push_req = in_valid && (ctrl_q == C_ACTIVE) && (in_count != 6'd0);
        full     = (occ_q == OCC_W'(DEPTH));
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    // Control: completion is judged on next-cycle FIFO/writer state so pixel_done
    // lands one cycle after the final accepted write.
    always_comb begin
        ctrl_d       = ctrl_q;
        pix_base_d   = pix_base_q;
        c_out_d      = c_out_q;
        written_d    = written_q + 11'(written_inc);
        seen_done_d  = seen_done_q;
        busy_d       = busy_q;
        pixel_done_d = 1'b0;
        overflow_d   = overflow_q;
        count_err_d  = count_err_q;
        case (ctrl_q)
            C_IDLE: begin
                if (start) begin
                    ctrl_d      = C_ACTIVE;
                    pix_base_d  = pix_base;
                    c_out_d     = c_out;
                    written_d   = '0;
                    seen_done_d = 1'b0;
                    overflow_d  = 1'b0;
                    count_err_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            C_ACTIVE: begin
                if (in_done) seen_done_d = 1'b1;
                if (drop)    overflow_d  = 1'b1;
                if (seen_done_q && (occ_d == '0) && (w_state_d == W_IDLE)) begin
                    ctrl_d       = C_DONE;
                    pixel_done_d = 1'b1;
                    busy_d       = 1'b0;
                    count_err_d  = (written_d != c_out_q);
                end
            end
            C_DONE:  ctrl_d = C_IDLE;
            default: ctrl_d = C_IDLE;
        endcase
    end

    // Batch payload capture at the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < LANES; i++) fifo_data_q[wr_ptr_q][i] <= in_data[i];
            fifo_ch_q[wr_ptr_q]  <= in_ch_base;
            fifo_cnt_q[wr_ptr_q] <= eff_cnt;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q       <= C_IDLE;
            w_state_q    <= W_IDLE;
            pix_base_q   <= '0;
            c_out_q      <= '0;
            written_q    <= '0;
            seen_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            pixel_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            count_err_q  <= 1'b0;
            lane_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            w_state_q    <= w_state_d;
            pix_base_q   <= pix_base_d;
            c_out_q      <= c_out_d;
            written_q    <= written_d;
            seen_done_q  <= seen_done_d;
            busy_q       <= busy_d;
            pixel_done_q <= pixel_done_d;
            overflow_q   <= overflow_d;
            count_err_q  <= count_err_d;
            lane_q       <= lane_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign pixel_done = pixel_done_q;
    assign overflow   = overflow_q;
    assign count_err  = count_err_q;

endmodule
